hazard_scoreboard: RTL and testbench

//  Parametrised register-hazard detector for the decode stage. Tracks the

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage register hazard detector: tracks in-flight destinations and stalls on source matches.
// Optional feature macro: ZERO_REG_HAZARD_EN (specifier 0 behaves as an ordinary register).
module hazard_scoreboard #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic                  issue_wr_en,
    input  logic [REG_W-1:0]      issue_dst,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*REG_W-1:0] src_reg,
    output logic                  hazard,
    output logic [NSRC-1:0]       match_vec,
    output logic [DEPTH-1:0]      match_stage,
    output logic [CNT_W-1:0]      stall_cnt
);

`ifdef ZERO_REG_HAZARD_EN
    localparam bit ZERO_REG_MATCHES = 1'b1;
`else
    localparam bit ZERO_REG_MATCHES = 1'b0;
`endif

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][REG_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]             src_ok;
    logic [DEPTH-1:0]            entry_hit;
    logic                        found;
    logic                        rec_v;

    // Qualify each source: valid, live decode slot, and not the hardwired-zero register.
    always_comb begin
        src_ok = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            src_ok[k] = src_valid[k] & issue_valid & ~flush &
                        (ZERO_REG_MATCHES | (src_reg[k*REG_W +: REG_W] != '0));
        end
    end

    // Full source x entry compare matrix, reduced both ways.
    always_comb begin
        match_vec = '0;
        entry_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                if (src_ok[k] && v_q[i] && (src_reg[k*REG_W +: REG_W] == dst_q[i])) begin
                    match_vec[k] = 1'b1;
                    entry_hit[i] = 1'b1;
                end
            end
        end
    end

    assign hazard = |match_vec;

    // Youngest matching entry wins.
    always_comb begin
        match_stage = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_hit[i] && !found) begin
                match_stage[i] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    assign rec_v = issue_valid & issue_wr_en & ~hazard &
                   (ZERO_REG_MATCHES | (issue_dst != '0));

    // Entry pipeline next state: flush beats hold beats shift.
    always_comb begin
        v_d   = v_q;
        dst_d = dst_q;
        if (flush) begin
            v_d = '0;
        end else if (advance) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_d[i]   = v_q[i-1];
                dst_d[i] = dst_q[i-1];
            end
            v_d[0]   = rec_v;
            dst_d[0] = issue_dst;
        end
    end

    // Saturating count of cycles actually stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && advance && hazard && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            dst_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            dst_q       <= dst_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second narrow-counter, deeper instance covers saturation.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       advance, flush, issue_valid, issue_wr_en;
    logic [2:0] issue_dst;
    logic [1:0] src_valid;
    logic [5:0] src_reg;

    logic        hazard;
    logic [1:0]  match_vec;
    logic [2:0]  match_stage;
    logic [15:0] stall_cnt;

    logic        s_hazard;
    logic [1:0]  s_match_vec;
    logic [3:0]  s_match_stage;
    logic [1:0]  s_stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(3), .DEPTH(3), .NSRC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_dst(issue_dst),
        .src_valid(src_valid), .src_reg(src_reg),
        .hazard(hazard), .match_vec(match_vec), .match_stage(match_stage),
        .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.REG_W(3), .DEPTH(4), .NSRC(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en), .issue_dst(issue_dst),
        .src_valid(src_valid), .src_reg(src_reg),
        .hazard(s_hazard), .match_vec(s_match_vec), .match_stage(s_match_stage),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with an active-looking decode slot
        rst_n = 1'b0; advance = 1'b1; flush = 1'b0;
        issue_valid = 1'b1; issue_wr_en = 1'b0; issue_dst = 3'd0;
        src_valid = 2'b11; src_reg = {3'd1, 3'd1};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_hazard", hazard, 0);
        chk("rst_match_vec", match_vec, 0);
        chk("rst_match_stage", match_stage, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Single write to r5 ages through all stages
        src_valid = 2'b00; issue_wr_en = 1'b1; issue_dst = 3'd5;
        #1 chk("t2_issue_nohaz", hazard, 0);
        step();
        issue_wr_en = 1'b0; src_valid = 2'b01; src_reg = {3'd0, 3'd5};
        #1;
        chk("t2_hazard", hazard, 1);
        chk("t2_match_vec", match_vec, 2'b01);
        chk("t2_stage0", match_stage, 3'b001);
        chk("t2_cnt0", stall_cnt, 0);
        step(); #1;
        chk("t2_stage1", match_stage, 3'b010);
        chk("t2_cnt1", stall_cnt, 1);
        step(); #1;
        chk("t2_stage2", match_stage, 3'b100);
        chk("t2_cnt2", stall_cnt, 2);
        step(); #1;
        chk("t2_aged_hazard", hazard, 0);
        chk("t2_aged_stage", match_stage, 0);
        chk("t2_cnt3", stall_cnt, 3);

        // Writes 4,2,4 -> entries e0=4 e1=2 e2=4
        src_valid = 2'b00; issue_wr_en = 1'b1;
        issue_dst = 3'd4; step();
        issue_dst = 3'd2; step();
        issue_dst = 3'd4; step();
        issue_wr_en = 1'b0; src_valid = 2'b10; src_reg = {3'd4, 3'd5};
        #1;
        chk("t3_hazard", hazard, 1);
        chk("t3_match_vec", match_vec, 2'b10);
        chk("t3_youngest", match_stage, 3'b001);
        src_valid = 2'b01; src_reg = {3'd4, 3'd2};
        #1 chk("t3_mid_stage", match_stage, 3'b010);
        src_valid = 2'b11;
        #1 chk("t3_both_vec", match_vec, 2'b11);

        // Hold with advance=0, then flush
        src_valid = 2'b00; issue_wr_en = 1'b1; issue_dst = 3'd6;
        step();
        advance = 1'b0; issue_dst = 3'd7; src_valid = 2'b01; src_reg = {3'd0, 3'd6};
        repeat (5) step();
        #1;
        chk("t4_hold_hazard", hazard, 1);
        chk("t4_hold_stage", match_stage, 3'b001);
        chk("t4_hold_cnt", stall_cnt, 3);
        src_reg = {3'd0, 3'd2};
        #1 chk("t4_hold_e2", match_stage, 3'b100);
        src_reg = {3'd0, 3'd7};
        #1 chk("t4_no_rec_held", hazard, 0);
        src_reg = {3'd0, 3'd6}; flush = 1'b1; advance = 1'b1;
        #1 chk("t4_flush_comb", hazard, 0);
        step();
        flush = 1'b0; issue_wr_en = 1'b0;
        #1;
        chk("t4_post_flush_haz", hazard, 0);
        chk("t4_post_flush_cnt", stall_cnt, 3);
        src_reg = {3'd0, 3'd2};
        #1 chk("t4_post_flush_e2", match_stage, 0);

        // Register 0 handling
        src_valid = 2'b00; issue_wr_en = 1'b1; issue_dst = 3'd0;
        step();
        issue_wr_en = 1'b0; src_valid = 2'b01; src_reg = {3'd0, 3'd0};
        #1;
`ifdef ZERO_REG_HAZARD_EN
        chk("t5_zero_reg", hazard, 1);
`else
        chk("t5_zero_reg", hazard, 0);
`endif
        src_valid = 2'b00;

        // Async reset mid-operation with a live hazard
        issue_wr_en = 1'b1; issue_dst = 3'd3;
        step();
        issue_wr_en = 1'b0; src_valid = 2'b01; src_reg = {3'd0, 3'd3};
        #1 chk("rst_mid_pre", hazard, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hazard", hazard, 0);
        chk("rst_mid_stage", match_stage, 0);
        chk("rst_mid_cnt", stall_cnt, 0);
        chk("rst_mid_sat_cnt", s_stall_cnt, 0);
        rst_n = 1'b1; src_valid = 2'b00;

        // Saturation on the 2-bit counter instance
        issue_wr_en = 1'b1; issue_dst = 3'd3;
        step();
        issue_wr_en = 1'b0; src_valid = 2'b01; src_reg = {3'd0, 3'd3};
        #1 chk("t6_hazard", s_hazard, 1);
        step(); #1 chk("t6_sat1", s_stall_cnt, 1);
        step(); #1 chk("t6_sat2", s_stall_cnt, 2);
        step(); #1 chk("t6_sat3", s_stall_cnt, 3);
        chk("t6_sat_haz_still", s_hazard, 1);
        step(); #1 chk("t6_sat_hold", s_stall_cnt, 3);
        chk("t6_main_cnt", stall_cnt, 3);
        chk("t6_main_hazard", hazard, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
